// File: rtl/timer_alarm_pkg.sv
// Shared timer alarm register definitions: field widths, state encoding, register map.
package timer_alarm_pkg;

  localparam int TIMER_ALARM_LOAD_LOW_W  = 32;
  localparam int TIMER_ALARM_LOAD_HIGH_W = 32;
  localparam int TIMER_ALARM_COUNT_W     = TIMER_ALARM_LOAD_LOW_W + TIMER_ALARM_LOAD_HIGH_W;
  localparam int TIMER_ALARM_PRESCALE_W  = 16;

  typedef enum logic {
    ALARM_IDLE = 1'b0,
    ALARM_RUN  = 1'b1
  } alarm_state_e;

  localparam logic [3:0] TIMER_ALARM_ADDR_LOAD_LOW  = 4'h0;
  localparam logic [3:0] TIMER_ALARM_ADDR_LOAD_HIGH = 4'h1;
  localparam logic [3:0] TIMER_ALARM_ADDR_CTRL      = 4'h2;
  localparam logic [3:0] TIMER_ALARM_ADDR_ACK       = 4'h3;
  localparam logic [3:0] TIMER_ALARM_ADDR_REMAIN    = 4'h4;
  localparam logic [3:0] TIMER_ALARM_ADDR_STATUS    = 4'h5;

  // CTRL register bit positions
  localparam int TIMER_ALARM_CTRL_START_BIT    = 0;
  localparam int TIMER_ALARM_CTRL_STOP_BIT     = 1;
  localparam int TIMER_ALARM_CTRL_PERIODIC_BIT = 2;

endpackage

// File: rtl/timer_alarm_if.sv
// Register-bank side of the timer alarm: write strobes in, status out.
// ALARM_PRESCALE exists only when TIMER_ALARM_PRESCALE_EN is defined.
interface timer_alarm_if #(
    parameter int DATA_W = 32
);

    logic [DATA_W-1:0]   ALARM_LOAD_LOW;
    logic                ALARM_LOAD_LOW_WR;
    logic [DATA_W-1:0]   ALARM_LOAD_HIGH;
    logic                ALARM_LOAD_HIGH_WR;
    logic                ALARM_START;
    logic                ALARM_STOP;
    logic                ALARM_PERIODIC;
    logic                ALARM_ACK;
    logic [2*DATA_W-1:0] ALARM_REMAIN;
    logic                ALARM_BUSY;
    logic                ALARM_IRQ;
    logic                ALARM_MISSED;
`ifdef TIMER_ALARM_PRESCALE_EN
    logic [15:0]         ALARM_PRESCALE;

    modport master (
        output ALARM_LOAD_LOW, ALARM_LOAD_LOW_WR, ALARM_LOAD_HIGH, ALARM_LOAD_HIGH_WR,
        output ALARM_START, ALARM_STOP, ALARM_PERIODIC, ALARM_ACK, ALARM_PRESCALE,
        input  ALARM_REMAIN, ALARM_BUSY, ALARM_IRQ, ALARM_MISSED
    );

    modport slave (
        input  ALARM_LOAD_LOW, ALARM_LOAD_LOW_WR, ALARM_LOAD_HIGH, ALARM_LOAD_HIGH_WR,
        input  ALARM_START, ALARM_STOP, ALARM_PERIODIC, ALARM_ACK, ALARM_PRESCALE,
        output ALARM_REMAIN, ALARM_BUSY, ALARM_IRQ, ALARM_MISSED
    );
`else
    modport master (
        output ALARM_LOAD_LOW, ALARM_LOAD_LOW_WR, ALARM_LOAD_HIGH, ALARM_LOAD_HIGH_WR,
        output ALARM_START, ALARM_STOP, ALARM_PERIODIC, ALARM_ACK,
        input  ALARM_REMAIN, ALARM_BUSY, ALARM_IRQ, ALARM_MISSED
    );

    modport slave (
        input  ALARM_LOAD_LOW, ALARM_LOAD_LOW_WR, ALARM_LOAD_HIGH, ALARM_LOAD_HIGH_WR,
        input  ALARM_START, ALARM_STOP, ALARM_PERIODIC, ALARM_ACK,
        output ALARM_REMAIN, ALARM_BUSY, ALARM_IRQ, ALARM_MISSED
    );
`endif

endinterface

// File: rtl/timer_alarm_prescaler.sv
// Tick generator: one tick every prescale+1 cycles; clear restarts the phase.
module timer_alarm_prescaler
    import timer_alarm_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [TIMER_ALARM_PRESCALE_W-1:0] prescale,
    output logic                              tick
);

    logic [TIMER_ALARM_PRESCALE_W-1:0] phase_q;

    // >= so that lowering prescale below the current phase cannot stall the tick
    assign tick = (phase_q >= prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (clear || tick) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/timer_alarm_core.sv
// Countdown alarm: software loads a 2*DATA_W interval, hardware counts it to zero
// and raises a sticky IRQ. Optional prescaler under TIMER_ALARM_PRESCALE_EN.
module timer_alarm_core
    import timer_alarm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    timer_alarm_if.slave bus
);

    localparam int COUNT_W = 2 * DATA_W;

    alarm_state_e        state_q, state_d;
    logic [DATA_W-1:0]   load_low_q, load_high_q;
    logic [COUNT_W-1:0]  load_val;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                irq_q, irq_d;
    logic                missed_q, missed_d;
    logic                tick;

    assign load_val = {load_high_q, load_low_q};

`ifdef TIMER_ALARM_PRESCALE_EN
    timer_alarm_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.ALARM_START || bus.ALARM_STOP),
        .prescale (bus.ALARM_PRESCALE),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_low_q  <= '0;
            load_high_q <= '0;
        end else begin
            if (bus.ALARM_LOAD_LOW_WR)  load_low_q  <= bus.ALARM_LOAD_LOW;
            if (bus.ALARM_LOAD_HIGH_WR) load_high_q <= bus.ALARM_LOAD_HIGH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ALARM_IDLE;
            count_q  <= '0;
            irq_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        irq_d    = irq_q;
        missed_d = missed_q;

        if (bus.ALARM_ACK) begin
            irq_d    = 1'b0;
            missed_d = 1'b0;
        end

        if (bus.ALARM_STOP) begin
            state_d = ALARM_IDLE;
            count_d = '0;
        end else if (bus.ALARM_START) begin
            if (load_val != '0) begin
                state_d = ALARM_RUN;
                count_d = load_val;
            end else begin
                state_d = ALARM_IDLE;
                count_d = '0;
            end
        end else if (state_q == ALARM_RUN && tick) begin
            if (count_q == COUNT_W'(1)) begin
                // expiry overrides a same-cycle ACK for IRQ; ACK still suppresses MISSED
                irq_d = 1'b1;
                if (irq_q && !bus.ALARM_ACK) missed_d = 1'b1;
                if (bus.ALARM_PERIODIC && load_val != '0) begin
                    count_d = load_val;
                end else begin
                    state_d = ALARM_IDLE;
                    count_d = '0;
                end
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    assign bus.ALARM_REMAIN = count_q;
    assign bus.ALARM_BUSY   = (state_q == ALARM_RUN);
    assign bus.ALARM_IRQ    = irq_q;
    assign bus.ALARM_MISSED = missed_q;

endmodule

// File: tb/tb_timer_alarm_core.sv
// Directed self-checking bench for timer_alarm_core; prescaler cases run only
// when TIMER_ALARM_PRESCALE_EN is defined.
module tb_timer_alarm_core;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    timer_alarm_if #(.DATA_W(32)) bus ();

    timer_alarm_core #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_load(input logic [63:0] v);
        bus.ALARM_LOAD_LOW     = v[31:0];
        bus.ALARM_LOAD_HIGH    = v[63:32];
        bus.ALARM_LOAD_LOW_WR  = 1'b1;
        bus.ALARM_LOAD_HIGH_WR = 1'b1;
        cyc();
        bus.ALARM_LOAD_LOW_WR  = 1'b0;
        bus.ALARM_LOAD_HIGH_WR = 1'b0;
    endtask

    task automatic pulse_start();
        bus.ALARM_START = 1'b1;
        cyc();
        bus.ALARM_START = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.ALARM_STOP = 1'b1;
        cyc();
        bus.ALARM_STOP = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ALARM_ACK = 1'b1;
        cyc();
        bus.ALARM_ACK = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.ALARM_LOAD_LOW     = '0;
        bus.ALARM_LOAD_LOW_WR  = 1'b0;
        bus.ALARM_LOAD_HIGH    = '0;
        bus.ALARM_LOAD_HIGH_WR = 1'b0;
        bus.ALARM_START        = 1'b0;
        bus.ALARM_STOP         = 1'b0;
        bus.ALARM_PERIODIC     = 1'b0;
        bus.ALARM_ACK          = 1'b0;
`ifdef TIMER_ALARM_PRESCALE_EN
        bus.ALARM_PRESCALE     = '0;
`endif
        cyc();
        cyc();
        check("rst_remain", bus.ALARM_REMAIN, 64'd0);
        check("rst_busy",   bus.ALARM_BUSY,   64'd0);
        check("rst_irq",    bus.ALARM_IRQ,    64'd0);
        check("rst_missed", bus.ALARM_MISSED, 64'd0);
        rst_n = 1'b1;
        cyc();

        // one-shot, N=5
        write_load(64'd5);
        pulse_start();
        check("os_remain5", bus.ALARM_REMAIN, 64'd5);
        check("os_busy",    bus.ALARM_BUSY,   64'd1);
        for (int k = 4; k >= 1; k--) begin
            cyc();
            check("os_remain", bus.ALARM_REMAIN, 64'(k));
            check("os_irq_lo", bus.ALARM_IRQ,    64'd0);
        end
        cyc();
        check("os_irq",      bus.ALARM_IRQ,    64'd1);
        check("os_busy_end", bus.ALARM_BUSY,   64'd0);
        check("os_rem_end",  bus.ALARM_REMAIN, 64'd0);
        cyc();
        check("os_irq_hold", bus.ALARM_IRQ,    64'd1);
        pulse_ack();
        check("os_ack",      bus.ALARM_IRQ,    64'd0);

        // periodic, N=3, reload rewritten to 2 mid-run
        write_load(64'd3);
        bus.ALARM_PERIODIC = 1'b1;
        pulse_start();
        check("per_rem3", bus.ALARM_REMAIN, 64'd3);
        cyc();
        cyc();
        check("per_rem1", bus.ALARM_REMAIN, 64'd1);
        cyc();
        check("per_irq1",    bus.ALARM_IRQ,    64'd1);
        check("per_reload3", bus.ALARM_REMAIN, 64'd3);
        check("per_miss0",   bus.ALARM_MISSED, 64'd0);
        check("per_busy",    bus.ALARM_BUSY,   64'd1);
        write_load(64'd2);
        check("per_wr_nodist", bus.ALARM_REMAIN, 64'd2);
        cyc();
        cyc();
        check("per_missed",  bus.ALARM_MISSED, 64'd1);
        check("per_reload2", bus.ALARM_REMAIN, 64'd2);
        pulse_stop();
        check("stop_busy",   bus.ALARM_BUSY,   64'd0);
        check("stop_rem",    bus.ALARM_REMAIN, 64'd0);
        check("stop_irq",    bus.ALARM_IRQ,    64'd1);
        check("stop_missed", bus.ALARM_MISSED, 64'd1);
        pulse_ack();
        check("ack_irq",    bus.ALARM_IRQ,    64'd0);
        check("ack_missed", bus.ALARM_MISSED, 64'd0);
        bus.ALARM_PERIODIC = 1'b0;

        // START with zero load is ignored
        write_load(64'd0);
        pulse_start();
        check("zero_busy", bus.ALARM_BUSY, 64'd0);
        check("zero_irq",  bus.ALARM_IRQ,  64'd0);

        // restart in RUN; same-cycle write not seen by START
        write_load(64'd10);
        pulse_start();
        cyc();
        cyc();
        check("rs_rem8", bus.ALARM_REMAIN, 64'd8);
        bus.ALARM_LOAD_LOW    = 32'd7;
        bus.ALARM_LOAD_LOW_WR = 1'b1;
        pulse_start();
        bus.ALARM_LOAD_LOW_WR = 1'b0;
        check("rs_rem10", bus.ALARM_REMAIN, 64'd10);
        pulse_start();
        check("rs_rem7", bus.ALARM_REMAIN, 64'd7);

        // STOP beats START
        bus.ALARM_STOP = 1'b1;
        pulse_start();
        bus.ALARM_STOP = 1'b0;
        check("ss_busy", bus.ALARM_BUSY,   64'd0);
        check("ss_rem",  bus.ALARM_REMAIN, 64'd0);

        // borrow across the 32-bit halves
        write_load(64'h1_0000_0000);
        pulse_start();
        check("brw_hi", bus.ALARM_REMAIN, 64'h1_0000_0000);
        cyc();
        check("brw_lo", bus.ALARM_REMAIN, 64'h0_FFFF_FFFF);
        pulse_stop();

        // maximum interval
        write_load(64'hFFFF_FFFF_FFFF_FFFF);
        pulse_start();
        check("max_rem", bus.ALARM_REMAIN, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        check("max_dec", bus.ALARM_REMAIN, 64'hFFFF_FFFF_FFFF_FFFE);
        pulse_stop();

        // expiry with ACK while IRQ already set: IRQ stays, MISSED not set
        write_load(64'd1);
        pulse_start();
        cyc();
        check("ea_irq_pre", bus.ALARM_IRQ, 64'd1);
        pulse_start();
        pulse_ack();
        check("ea_irq",    bus.ALARM_IRQ,    64'd1);
        check("ea_missed", bus.ALARM_MISSED, 64'd0);
        pulse_ack();

`ifdef TIMER_ALARM_PRESCALE_EN
        begin
            int n;
            bus.ALARM_PRESCALE = 16'd3;
            write_load(64'd2);
            pulse_start();
            n = 0;
            while (bus.ALARM_IRQ !== 1'b1 && n < 40) begin
                cyc();
                n++;
            end
            check("pre_lat", 64'(n), 64'd8);
            pulse_ack();
            pulse_start();
            cyc();
            cyc();
            pulse_start();
            n = 0;
            while (bus.ALARM_IRQ !== 1'b1 && n < 40) begin
                cyc();
                n++;
            end
            check("pre_restart", 64'(n), 64'd8);
            pulse_ack();
            bus.ALARM_PRESCALE = 16'd0;
        end
`endif

        // asynchronous reset mid-RUN with IRQ pending
        write_load(64'd2);
        bus.ALARM_PERIODIC = 1'b1;
        pulse_start();
        cyc();
        cyc();
        check("ar_pre_irq",  bus.ALARM_IRQ,  64'd1);
        check("ar_pre_busy", bus.ALARM_BUSY, 64'd1);
        rst_n = 1'b0;
        #2;
        check("ar_remain", bus.ALARM_REMAIN, 64'd0);
        check("ar_busy",   bus.ALARM_BUSY,   64'd0);
        check("ar_irq",    bus.ALARM_IRQ,    64'd0);
        check("ar_missed", bus.ALARM_MISSED, 64'd0);
        bus.ALARM_PERIODIC = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
